ifetch_queue: RTL

- Instruction fetch/prefetch stage placed directly upstream of the SISC instruction register.
- Drives the instruction-memory read address and captures the returned words into a small FIFO.
- Presents the oldest buffered instruction and its PC to the IR/ctrl side through a valid/ready handshake.
- Redirects and flushes on a taken branch, and stops prefetching after it has queued a HALT opcode.

---
 rtl/sisc_pkg.sv | 21 ++
 rtl/ifq_ram.sv | 28 ++
 rtl/ifetch_queue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: fetch-stage state encoding, HALT opcode and
// the default address/data widths used by pc, ir and instruction memory.
package sisc_pkg;

  localparam int SISC_AW = 16;
  localparam int SISC_DW = 32;

  localparam logic [3:0] SISC_HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ifq_state_e;

  // True when the opcode field of a fetched word is the halt opcode.
  function automatic logic is_halt_op(input logic [3:0] opcode, input logic [3:0] halt_op);
    return opcode == halt_op;
  endfunction

endpackage

// File: rtl/ifq_ram.sv
// Instruction queue storage: DEPTH x W register array, synchronous write,
// asynchronous read. Contents are deliberately not reset; validity is
// tracked by the occupancy count in the parent.
module ifq_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 48,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the pushed entry at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch / prefetch queue feeding the SISC instruction register.
// Drives im_addr from fetch_pc, buffers returned words with their PC, and
// hands the oldest one out over a valid/ready handshake. A taken branch
// flushes the queue and redirects; queuing a HALT word stops prefetch.
// Optional statistics counters (stall_cnt, flush_cnt) exist only when the
// macro IFQ_STATS_EN is defined.
module ifetch_queue
  import sisc_pkg::*;
#(
  parameter int             DEPTH    = 4,
  parameter int             AW       = SISC_AW,
  parameter int             DW       = SISC_DW,
  parameter logic [AW-1:0]  RESET_PC = '0,
  parameter logic [3:0]     HALT_OP  = SISC_HALT_OP
) (
  input  logic                       clk,
  input  logic                       rst_f,
  output logic [AW-1:0]              im_addr,
  input  logic [DW-1:0]              im_data,
  input  logic                       br_taken,
  input  logic [AW-1:0]              br_addr,
  output logic [DW-1:0]              instr,
  output logic [AW-1:0]              instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] q_count
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ifq_state_e    state_reg,    state_next;
  logic [AW-1:0] fetch_pc_reg, fetch_pc_next;
  logic [PW-1:0] rd_ptr_reg,   rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg,   wr_ptr_next;
  logic [CW-1:0] count_reg,    count_next;

  logic          flush;
  logic          push;
  logic          pop;
  logic [DW+AW-1:0] head_entry;

  // Handshake qualifiers; a full queue never pushes, even if it pops now.
  always_comb begin
    flush = br_taken && (state_reg != BOOT);
    push  = (state_reg == RUN) && (count_reg != FULL) && !br_taken;
    pop   = (count_reg != '0) && instr_ready && !br_taken;
  end

  // Next-state logic for FSM, fetch PC, pointers and occupancy.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;

    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     if (push && is_halt_op(im_data[DW-1 -: 4], HALT_OP)) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = BOOT;
    endcase

    if (flush) begin
      state_next    = RUN;
      fetch_pc_next = br_addr;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (push) begin
        wr_ptr_next   = wr_ptr_reg + PW'(1);
        fetch_pc_next = fetch_pc_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_reg    <= BOOT;
      fetch_pc_reg <= RESET_PC;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

  ifq_ram #(
    .DEPTH (DEPTH),
    .W     (DW + AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata ({im_data, fetch_pc_reg}),
    .raddr (rd_ptr_reg),
    .rdata (head_entry)
  );

  // Head entry is masked to zero when empty so stale storage never leaks out.
  assign im_addr     = fetch_pc_reg;
  assign q_count     = count_reg;
  assign instr_valid = (count_reg != '0);
  assign instr       = instr_valid ? head_entry[DW+AW-1:AW] : '0;
  assign instr_pc    = instr_valid ? head_entry[AW-1:0]     : '0;

`ifdef IFQ_STATS_EN
  logic [15:0] stall_cnt_reg;
  logic [15:0] flush_cnt_reg;

  // Saturating counters of full-queue stall cycles and accepted flushes.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if ((state_reg == RUN) && (count_reg == FULL) && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      if (flush && (flush_cnt_reg != 16'hFFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule
